// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry and gray-code helpers.
// The helpers work on a 32-bit container and take the active width as an argument.
package fifo_pkg;

  localparam int unsigned FIFO_ADRRSIZE = 3;
  localparam int unsigned DEPTH         = 1 << FIFO_ADRRSIZE;

  function automatic int unsigned fifo_depth(input int unsigned adrrsize);
    return 1 << adrrsize;
  endfunction

  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] m;
    m = b & width_mask(w);
    return m ^ (m >> 1);
  endfunction

  // Each binary bit is the XOR of its gray bit and every gray bit above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] m;
    logic [31:0] b;
    m = g & width_mask(w);
    b = m;
    for (int unsigned s = 1; s < 32; s++) begin
      b = b ^ (m >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational gray-to-binary decoder, shared by the read- and write-side level blocks.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = WIDTH'(gray2bin(32'(gray), WIDTH));
  end

endmodule

// File: rtl/fifo_rptr_lvl.sv
// Read-side pointer, empty/almost-empty flags, fill level and sticky underflow
// for the dual-clock FIFO; everything here lives in the rclk domain.
module fifo_rptr_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned ADRRSIZE  = 3,
  parameter bit          EMPTY_REG = 1'b1,
  parameter int unsigned AE_RST    = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADRRSIZE:0]   rq2_wptr,
  input  logic [ADRRSIZE:0]   rae_thresh,
  input  logic                rae_load,
  input  logic                rclr_err,
  output logic [ADRRSIZE-1:0] raddr,
  output logic [ADRRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADRRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int unsigned   PW       = ADRRSIZE + 1;
  localparam logic [PW-1:0] AE_RST_V = PW'(AE_RST);

  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rbin_nxt;
  logic [PW-1:0] rgray_nxt;
  logic [PW-1:0] wbin;
  logic [PW-1:0] lvl_nxt;
  logic [PW-1:0] ae_thresh;
  logic          rd_en;

  fifo_gray2bin #(
    .WIDTH (PW)
  ) u_wdec (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  always_comb begin
    rd_en     = rinc & ~rempty;
    rbin_nxt  = rptr_bin + PW'(rd_en);
    rgray_nxt = PW'(bin2gray(32'(rbin_nxt), PW));
    lvl_nxt   = wbin - rbin_nxt;
  end

  assign raddr = rptr_bin[ADRRSIZE-1:0];

  // Flags and level are computed from the next-state pointer so they line up
  // with the edge that moves the pointer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_bin      <= '0;
      rptr_gray     <= '0;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
      ae_thresh     <= AE_RST_V;
    end else begin
      rptr_bin      <= rbin_nxt;
      rptr_gray     <= rgray_nxt;
      rlevel        <= lvl_nxt;
      ralmost_empty <= (lvl_nxt <= ae_thresh);
      if (rae_load) begin
        ae_thresh <= rae_thresh;
      end
    end
  end

  // Set has priority over clear so an underflow in the clearing cycle is kept.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end else if (rclr_err) begin
      runderflow <= 1'b0;
    end
  end

  if (EMPTY_REG) begin : g_empty_reg
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        rempty <= 1'b1;
      end else begin
        rempty <= (rgray_nxt == rq2_wptr);
      end
    end
  end else begin : g_empty_comb
    assign rempty = (rptr_gray == rq2_wptr);
  end

endmodule

// File: tb/tb_fifo_rptr_lvl.sv
// Directed bench for fifo_rptr_lvl: registered-empty and combinational-empty
// builds driven in lockstep with hand-computed expectations.
module tb_fifo_rptr_lvl;
  import fifo_pkg::*;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [3:0] rq2_wptr;
  logic [3:0] rae_thresh;
  logic       rae_load;
  logic       rclr_err;

  logic [2:0] raddr,   raddr_c;
  logic [3:0] rptr_gray, rptr_gray_c;
  logic       rempty,  rempty_c;
  logic       rae,     rae_c;
  logic [3:0] rlevel,  rlevel_c;
  logic       ruf,     ruf_c;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  fifo_rptr_lvl #(
    .ADRRSIZE  (3),
    .EMPTY_REG (1'b1),
    .AE_RST    (1)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rae_thresh    (rae_thresh),
    .rae_load      (rae_load),
    .rclr_err      (rclr_err),
    .raddr         (raddr),
    .rptr_gray     (rptr_gray),
    .rempty        (rempty),
    .ralmost_empty (rae),
    .rlevel        (rlevel),
    .runderflow    (ruf)
  );

  fifo_rptr_lvl #(
    .ADRRSIZE  (3),
    .EMPTY_REG (1'b0),
    .AE_RST    (1)
  ) dut_c (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rae_thresh    (rae_thresh),
    .rae_load      (rae_load),
    .rclr_err      (rclr_err),
    .raddr         (raddr_c),
    .rptr_gray     (rptr_gray_c),
    .rempty        (rempty_c),
    .ralmost_empty (rae_c),
    .rlevel        (rlevel_c),
    .runderflow    (ruf_c)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Checks both builds; the combinational build's rempty is skipped when it
  // legitimately differs (reset held with a non-zero write pointer).
  task automatic exp_state(input string tag, input logic [3:0] g, input logic [2:0] a,
                           input logic [3:0] lvl, input logic e, input logic ae,
                           input logic uf, input bit chk_c_empty);
    check_eq({tag, "/gray"},  32'(rptr_gray), 32'(g));
    check_eq({tag, "/addr"},  32'(raddr),     32'(a));
    check_eq({tag, "/level"}, 32'(rlevel),    32'(lvl));
    check_eq({tag, "/empty"}, 32'(rempty),    32'(e));
    check_eq({tag, "/ae"},    32'(rae),       32'(ae));
    check_eq({tag, "/uf"},    32'(ruf),       32'(uf));
    check_eq({tag, "/c_gray"},  32'(rptr_gray_c), 32'(g));
    check_eq({tag, "/c_addr"},  32'(raddr_c),     32'(a));
    check_eq({tag, "/c_level"}, 32'(rlevel_c),    32'(lvl));
    check_eq({tag, "/c_ae"},    32'(rae_c),       32'(ae));
    check_eq({tag, "/c_uf"},    32'(ruf_c),       32'(uf));
    if (chk_c_empty) begin
      check_eq({tag, "/c_empty"}, 32'(rempty_c), 32'(e));
    end
  endtask

  initial begin
    rrst_n = 1'b1; rinc = 1'b0; rq2_wptr = '0;
    rae_thresh = '0; rae_load = 1'b0; rclr_err = 1'b0;

    // reset
    #2 rrst_n = 1'b0;
    #1 exp_state("rst", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    rrst_n = 1'b1;

    // underflow while empty
    rinc = 1'b1;
    tick(); exp_state("t1_uf1", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    exp_state("t1_uf3", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    rinc = 1'b0; rclr_err = 1'b1;
    tick(); exp_state("t1_clr", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    rinc = 1'b1;
    tick(); exp_state("t1_setwins", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    rinc = 1'b0;
    tick(); exp_state("t1_clr2", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    rclr_err = 1'b0;

    // three writes, three reads
    rq2_wptr = 4'd1;
    #1;
    check_eq("t2_comb_fall", 32'(rempty_c), 32'd0);
    check_eq("t2_reg_hold",  32'(rempty),   32'd1);
    tick(); exp_state("t2_w1", 4'd0, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    rq2_wptr = 4'd3;
    tick(); exp_state("t2_w2", 4'd0, 3'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    rq2_wptr = 4'd2;
    tick(); exp_state("t2_w3", 4'd0, 3'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_addr0", 32'(raddr), 32'd0);
    rinc = 1'b1;
    tick(); exp_state("t2_r1", 4'd1, 3'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); exp_state("t2_r2", 4'd3, 3'd2, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); exp_state("t2_r3", 4'd2, 3'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    rinc = 1'b0;

    // full, drain and wrap
    rq2_wptr = 4'd0; rrst_n = 1'b0;
    tick();
    rrst_n = 1'b1; rq2_wptr = 4'b1100;
    tick(); exp_state("t3_full", 4'd0, 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_eq("t3_addr", 32'(raddr), 32'(i));
      rinc = 1'b1;
      tick();
      exp_state("t3_rd", gray_tbl[i+1], 3'(i + 1), 4'(7 - i), (i == 7), ((7 - i) <= 1), 1'b0, 1'b1);
    end
    rinc = 1'b0;
    rq2_wptr = 4'b1011;
    tick(); exp_state("t3_w13", 4'b1100, 3'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      check_eq("t3_waddr", 32'(raddr), 32'(j));
      rinc = 1'b1;
      tick();
      exp_state("t3_wrd", gray_tbl[9+j], 3'(j + 1), 4'(4 - j), (j == 4), ((4 - j) <= 1), 1'b0, 1'b1);
    end
    rinc = 1'b0;

    // almost-empty threshold
    rae_thresh = 4'd2; rae_load = 1'b1;
    tick(); rae_load = 1'b0;
    rq2_wptr = 4'd1;
    tick(); exp_state("t4_lvl4", 4'd11, 3'd5, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    rinc = 1'b1;
    tick(); exp_state("t4_lvl3", 4'd9, 3'd6, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); exp_state("t4_lvl2", 4'd8, 3'd7, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    rq2_wptr = 4'd3;
    tick(); exp_state("t4_wr_rd", 4'd0, 3'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    rinc = 1'b0;
    rae_thresh = 4'd0; rae_load = 1'b1;
    tick(); rae_load = 1'b0;
    exp_state("t4_ld0_old", 4'd0, 3'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); exp_state("t4_th0", 4'd0, 3'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    rae_thresh = 4'(DEPTH); rae_load = 1'b1;
    tick(); rae_load = 1'b0;
    exp_state("t4_ld8_old", 4'd0, 3'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); exp_state("t4_th8", 4'd0, 3'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    rae_thresh = 4'd0; rae_load = 1'b1;
    tick(); rae_load = 1'b0;
    rinc = 1'b1;
    tick(); exp_state("t4_th0_l1", 4'd1, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); exp_state("t4_th0_l0", 4'd3, 3'd2, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    rinc = 1'b0;

    // async reset mid-burst
    rq2_wptr = 4'b1100;
    tick(); exp_state("t6_lvl6", 4'd3, 3'd2, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    rinc = 1'b1;
    tick(); exp_state("t6_lvl5", 4'd2, 3'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    rrst_n = 1'b0;
    #1 exp_state("t6_async", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    rinc = 1'b0; rq2_wptr = 4'd0;
    #1 check_eq("t6_c_empty", 32'(rempty_c), 32'd1);
    tick();
    rrst_n = 1'b1;
    tick(); exp_state("t6_rel", 4'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    rq2_wptr = 4'd1;
    tick(); exp_state("t6_thr_rst", 4'd0, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rptr_lvl.md
Name: fifo_rptr_lvl

Overview:
Read-side pointer and flag generator for the dual-clock FIFO, running entirely in the read clock domain. It supersedes the basic read-pointer block:
- depth is parametrised;
- empty is registered and glitch-free, with a legacy combinational mode kept selectable;
- the synchronised write pointer is gray-decoded to give a read-side fill level;
- a programmable almost-empty flag and a sticky underflow error are added.
It sits between the read-port RAM address and the write-pointer 2-FF synchroniser.

Parameters:
ADRRSIZE, 3, address width; FIFO depth = 2**ADRRSIZE; pointers are ADRRSIZE+1 bits.
EMPTY_REG, 1, 1 = rempty registered from next-state pointer; 0 = legacy combinational compare.
AE_RST, 1, reset value of the internal almost-empty threshold register.

Ports:
rclk  in  1  read clock; the only clock.
rrst_n  in  1  asynchronous active-low reset, released synchronously to rclk upstream.
rinc  in  1  read request; honoured only when rempty=0.
rq2_wptr  in  ADRRSIZE+1  gray write pointer, already 2-FF synchronised into rclk.
rae_thresh  in  ADRRSIZE+1  almost-empty threshold; sampled when rae_load=1.
rae_load  in  1  load rae_thresh into the threshold register.
rclr_err  in  1  clears runderflow.
raddr  out  ADRRSIZE  RAM read address = rptr_bin[ADRRSIZE-1:0].
rptr_gray  out  ADRRSIZE+1  registered gray read pointer, sent to the write-domain synchroniser.
rempty  out  1  FIFO empty.
ralmost_empty  out  1  rlevel <= threshold.
rlevel  out  ADRRSIZE+1  words available, 0..2**ADRRSIZE.
runderflow  out  1  sticky: rinc was asserted while rempty=1.

Behaviour:
- Reset values (async, rrst_n=0): rptr_bin=0, rptr_gray=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0, threshold=AE_RST.
- Read enable: rd_en = rinc & ~rempty.
- Next-state pointers:
  - rbin_nxt = rptr_bin + rd_en, modulo 2**(ADRRSIZE+1), wrapping silently.
  - rgray_nxt = (rbin_nxt>>1) ^ rbin_nxt.
- Pointer registers: rptr_bin and rptr_gray register rbin_nxt and rgray_nxt every rclk. rptr_gray is a flop output, never combinational, so it is safe to cross domains.
- rempty, EMPTY_REG=1: registers (rgray_nxt == rq2_wptr).
  - Deasserts one rclk after rq2_wptr changes.
  - Asserts in the same edge as the read that consumes the last word.
- rempty, EMPTY_REG=0: combinational (rptr_gray == rq2_wptr). Provided for legacy compatibility only.
- Write pointer decode: wbin = gray-to-binary(rq2_wptr), XOR-prefix from the MSB down.
- rlevel: registers (wbin - rbin_nxt), modulo 2**(ADRRSIZE+1).
  - Exact range 0..DEPTH; full reads as DEPTH (MSB set, other bits 0).
  - Updates in the same edge as rempty.
- ralmost_empty: registers ((wbin - rbin_nxt) <= threshold). Comparison is unsigned, ADRRSIZE+1 bits.
  - Threshold 0 makes it equal to rempty.
  - Threshold >= DEPTH makes it always 1.
- Threshold register: loaded on rae_load. The new value takes effect on flags from the next edge.
- Underflow:
  - rinc=1 while rempty=1 sets runderflow on the next edge; the pointer does not move.
  - rclr_err=1 clears runderflow.
  - Simultaneous set and clear: set wins.
- Simultaneous read and rq2_wptr change in the same cycle: both are reflected in the next-edge rempty and rlevel. No word is lost or double-counted.
- Reset asserted mid-operation: all outputs return to reset values immediately (async). After release, the first read is possible only once rq2_wptr != 0.
- The block never writes RAM and never inspects the write clock.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parametrised on width;
  - localparam DEPTH = 1<<ADRRSIZE.
- One sub-module: fifo_gray2bin (combinational decoder, WIDTH parameter). It is reused by the upcoming write-side level block.

Test Plan:
1. Reset with rq2_wptr=0 -> rempty=1, ralmost_empty=1, rlevel=0, rptr_gray=0, raddr=0; rinc=1 for 3 cycles -> pointer stays 0, runderflow=1 from the first edge and holds; rclr_err pulse -> runderflow=0.
2. ADRRSIZE=3, rq2_wptr stepped gray 0→1→3→2 (3 writes) -> rempty falls one edge after the first change, rlevel=3; 3 reads -> raddr 0,1,2, rptr_gray 1,3,2, rempty=1 on the edge of the third read, rlevel=0.
3. Full and wrap-around: rq2_wptr=gray(8)=4'b1100 with rptr=0 -> rlevel=8, rempty=0; 8 reads -> rptr_gray=4'b1100, rempty=1; drive wptr to gray(13) and perform 5 reads -> raddr 0..4, rptr_bin=13, no spurious empty.
4. rae_thresh=2 loaded with level 4 -> ralmost_empty=0; read twice -> ralmost_empty=1 at level 2; one write plus one read in the same cycle -> level stays 2, flag stays 1.
5. EMPTY_REG=0 build, same stimulus as test 2 -> rempty tracks combinationally (same cycle as the rq2_wptr change); all other outputs identical to the EMPTY_REG=1 build.
6. Assert rrst_n low mid-burst at level 5 -> all outputs reset asynchronously before the next rclk edge; after release with rq2_wptr=0 -> rempty=1.
